// File: rtl/control_pipe.sv
// ID/EX, EX/MEM and MEM/WB control pipeline with load-use and branch-compare
// hazard detection, stall/flush generation and a saturating stall counter.
module control_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       Bus_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             Equal_i,
  input  logic [4:0]       RsAddr_i,
  input  logic [4:0]       RtAddr_i,
  input  logic [4:0]       RdAddr_i,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [4:0]       EXWAddr_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [4:0]       MEMWAddr_o,
  output logic             MEMRegWrite_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic [4:0]       WBAddr_o,
  output logic             Stall_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  // Bus_i layout: {ALUSrc, ALUOp[1:0], RegDst, MemRead, MemWrite, MemtoReg, RegWrite}
  logic       ex_alusrc, ex_regdst, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rt, ex_rd;
  logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [4:0] mem_waddr;
  logic       wb_memtoreg, wb_regwrite;
  logic [4:0] wb_waddr;
  logic [CNT_W-1:0] stall_cnt;
  logic       h_load_use, h_br_alu, h_br_load;

  function automatic logic src_match(input logic [4:0] a, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (a != 5'd0) && ((a == rs) || (a == rt));
  endfunction

  assign EXWAddr_o = ex_regdst ? ex_rd : ex_rt;

  always_comb begin
    h_load_use = ex_memread && src_match(ex_rt, RsAddr_i, RtAddr_i);
    h_br_alu   = Branch_i && ex_regwrite && src_match(EXWAddr_o, RsAddr_i, RtAddr_i);
    h_br_load  = Branch_i && mem_memread && src_match(mem_waddr, RsAddr_i, RtAddr_i);
  end

  // Stall wins over flush: a stalled branch is resolved once its operands are ready.
  assign Stall_o = h_load_use | h_br_alu | h_br_load;
  assign Flush_o = ~Stall_o & (Jump_i | (Branch_i & Equal_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_alusrc   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_regdst   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
    end else if (Stall_o) begin
      ex_alusrc   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_regdst   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
    end else begin
      ex_alusrc   <= Bus_i[7];
      ex_aluop    <= Bus_i[6:5];
      ex_regdst   <= Bus_i[4];
      ex_memread  <= Bus_i[3];
      ex_memwrite <= Bus_i[2];
      ex_memtoreg <= Bus_i[1];
      ex_regwrite <= Bus_i[0];
      ex_rt       <= RtAddr_i;
      ex_rd       <= RdAddr_i;
    end
  end

  // EX/MEM and MEM/WB always advance, stall or not.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_waddr    <= 5'd0;
      wb_memtoreg  <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_waddr     <= 5'd0;
    end else begin
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_regwrite <= ex_regwrite;
      mem_waddr    <= EXWAddr_o;
      wb_memtoreg  <= mem_memtoreg;
      wb_regwrite  <= mem_regwrite;
      wb_waddr     <= mem_waddr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (Stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ALUSrc_o      = ex_alusrc;
  assign ALUOp_o       = ex_aluop;
  assign MemRead_o     = mem_memread;
  assign MemWrite_o    = mem_memwrite;
  assign MEMWAddr_o    = mem_waddr;
  assign MEMRegWrite_o = mem_regwrite;
  assign MemtoReg_o    = wb_memtoreg;
  assign RegWrite_o    = wb_regwrite;
  assign WBAddr_o      = wb_waddr;
  assign StallCnt_o    = stall_cnt;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed hazard sequences plus random traffic, checked
// against an instruction-level model through an expected-output queue.
module tb_control_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] Bus_i;
  logic       Branch_i, Jump_i, Equal_i;
  logic [4:0] RsAddr_i, RtAddr_i, RdAddr_i;

  logic       ALUSrc_o, MemRead_o, MemWrite_o, MEMRegWrite_o, MemtoReg_o, RegWrite_o;
  logic       Stall_o, Flush_o;
  logic [1:0] ALUOp_o;
  logic [4:0] EXWAddr_o, MEMWAddr_o, WBAddr_o;
  logic [15:0] StallCnt_o;

  logic       a4_ALUSrc, a4_MemRead, a4_MemWrite, a4_MEMRegWrite, a4_MemtoReg, a4_RegWrite;
  logic       a4_Stall, a4_Flush;
  logic [1:0] a4_ALUOp;
  logic [4:0] a4_EXWAddr, a4_MEMWAddr, a4_WBAddr;
  logic [3:0] a4_StallCnt;

  control_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .Bus_i(Bus_i), .Branch_i(Branch_i), .Jump_i(Jump_i),
    .Equal_i(Equal_i), .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
    .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o), .EXWAddr_o(EXWAddr_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .MEMWAddr_o(MEMWAddr_o), .MEMRegWrite_o(MEMRegWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .WBAddr_o(WBAddr_o),
    .Stall_o(Stall_o), .Flush_o(Flush_o), .StallCnt_o(StallCnt_o)
  );

  control_pipe #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .Bus_i(Bus_i), .Branch_i(Branch_i), .Jump_i(Jump_i),
    .Equal_i(Equal_i), .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
    .ALUSrc_o(a4_ALUSrc), .ALUOp_o(a4_ALUOp), .EXWAddr_o(a4_EXWAddr), .MemRead_o(a4_MemRead),
    .MemWrite_o(a4_MemWrite), .MEMWAddr_o(a4_MEMWAddr), .MEMRegWrite_o(a4_MEMRegWrite),
    .MemtoReg_o(a4_MemtoReg), .RegWrite_o(a4_RegWrite), .WBAddr_o(a4_WBAddr),
    .Stall_o(a4_Stall), .Flush_o(a4_Flush), .StallCnt_o(a4_StallCnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] bus;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  localparam int W = 45;  // 25 output bits, 16-bit count, 4-bit count
  logic [W-1:0] exp_q[$];
  instr_t m_ex = '0, m_mem = '0, m_wb = '0;
  int     m_cnt = 0;
  logic   m_stall = 1'b0;
  int     n_tests = 0, n_fail = 0;

  function automatic logic [4:0] waddr(input instr_t i);
    return i.bus[4] ? i.rd : i.rt;
  endfunction

  function automatic logic src(input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt);
    return (a != 5'd0) && ((a == rs) || (a == rt));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [7:0] bus, input logic br, input logic jmp,
                      input logic eq, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd);
    logic h1, h2, h3, st, fl;
    logic [24:0] v;
    int c4, c16;
    @(negedge clk_i);
    rst_i = rst; Bus_i = bus; Branch_i = br; Jump_i = jmp; Equal_i = eq;
    RsAddr_i = rs; RtAddr_i = rt; RdAddr_i = rd;
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    end
    h1 = m_ex.bus[3] && src(m_ex.rt, rs, rt);
    h2 = br && m_ex.bus[0] && src(waddr(m_ex), rs, rt);
    h3 = br && m_mem.bus[3] && src(waddr(m_mem), rs, rt);
    st = h1 || h2 || h3;
    fl = !st && (jmp || (br && eq));
    v = {m_ex.bus[7], m_ex.bus[6:5], waddr(m_ex), m_mem.bus[3], m_mem.bus[2], waddr(m_mem),
         m_mem.bus[0], m_wb.bus[1], m_wb.bus[0], waddr(m_wb), st, fl};
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    exp_q.push_back({v, 16'(c16), 4'(c4)});
    m_stall = st;
    // effect of the coming rising edge
    if (rst) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = st ? instr_t'('0) : instr_t'({bus, rs, rt, rd});
      if (st) m_cnt++;
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [24:0] obs, obs4;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        obs  = {ALUSrc_o, ALUOp_o, EXWAddr_o, MemRead_o, MemWrite_o, MEMWAddr_o, MEMRegWrite_o,
                MemtoReg_o, RegWrite_o, WBAddr_o, Stall_o, Flush_o};
        obs4 = {a4_ALUSrc, a4_ALUOp, a4_EXWAddr, a4_MemRead, a4_MemWrite, a4_MEMWAddr,
                a4_MEMRegWrite, a4_MemtoReg, a4_RegWrite, a4_WBAddr, a4_Stall, a4_Flush};
        n_tests += 4;
        if (obs !== e[44:20]) begin
          n_fail++;
          $display("FAIL outputs t=%0t got=%h exp=%h", $time, obs, e[44:20]);
        end
        if (obs4 !== e[44:20]) begin
          n_fail++;
          $display("FAIL outputs_w4 t=%0t got=%h exp=%h", $time, obs4, e[44:20]);
        end
        if (StallCnt_o !== e[19:4]) begin
          n_fail++;
          $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, StallCnt_o, e[19:4]);
        end
        if (a4_StallCnt !== e[3:0]) begin
          n_fail++;
          $display("FAIL stall_cnt_w4 t=%0t got=%0d exp=%0d", $time, a4_StallCnt, e[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog t=%0t queue=%0d", $time, exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  localparam logic [7:0] LW   = 8'b10001011;
  localparam logic [7:0] ADD  = 8'b01110001;
  localparam logic [7:0] BEQ  = 8'b00100000;

  initial begin
    logic [7:0] b;
    logic br, jm, eq;
    logic [4:0] rs, rt, rd;
    int kind;
    rst_i = 1'b0; Bus_i = '0; Branch_i = 0; Jump_i = 0; Equal_i = 0;
    RsAddr_i = '0; RtAddr_i = '0; RdAddr_i = '0;

    // reset held with random bus
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 5'($urandom));
    // R-type rd=3 through the pipe
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    nops(3);
    // load-use, then same with rt=0
    step(1'b1, LW, 1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0);
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9);
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9);
    nops(3);
    step(1'b1, LW, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    nops(3);
    // branch after ALU
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7);
    step(1'b1, BEQ, 1'b1, 1'b0, 1'b1, 5'd7, 5'd2, 5'd0);
    step(1'b1, BEQ, 1'b1, 1'b0, 1'b1, 5'd7, 5'd2, 5'd0);
    nops(3);
    // branch after load: two stall cycles
    step(1'b1, LW, 1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0);
    for (int i = 0; i < 3; i++) step(1'b1, BEQ, 1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd0);
    nops(3);
    // jump
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    nops(3);
    // drive the 4-bit counter into saturation, then reset mid-stall
    for (int k = 0; k < 10; k++) begin
      step(1'b1, LW, 1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0);
      for (int i = 0; i < 3; i++) step(1'b1, BEQ, 1'b1, 1'b0, 1'b0, 5'd4, 5'd2, 5'd0);
    end
    step(1'b1, LW, 1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0);
    step(1'b1, BEQ, 1'b1, 1'b0, 1'b0, 5'd4, 5'd2, 5'd0);
    step(1'b0, BEQ, 1'b1, 1'b0, 1'b0, 5'd4, 5'd2, 5'd0);
    nops(2);

    // random traffic; a stalled instruction is re-presented as the upstream hold would
    b = '0; br = 0; jm = 0; eq = 0; rs = '0; rt = '0; rd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!m_stall) begin
        kind = $urandom_range(0, 4);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        eq = 1'($urandom);
        br = 1'b0; jm = 1'b0;
        case (kind)
          0: b = LW;
          1: b = ADD;
          2: begin b = BEQ; br = 1'b1; end
          3: begin b = 8'h00; jm = 1'b1; end
          default: b = 8'($urandom);
        endcase
      end
      step(($urandom_range(0, 99) != 0), b, br, jm, eq, rs, rt, rd);
    end
    nops(2);

    @(negedge clk_i);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
